// File: rtl/ks_pkg.sv
`default_nettype none
//==============================================================================
// Module : ks_pkg
// Desc   : Shared types and constants for the Karplus-Strong string voice.
// Rev    : 1.0 - initial release
//==============================================================================
package ks_pkg;

    localparam int          c_DATA_W_DEF = 16;
    localparam int          c_ADDR_W_DEF = 10;
    localparam logic [31:0] c_MIN_DIV    = 32'd5;
    localparam int unsigned c_MIN_LEN    = 2;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RDA  = 3'd1,
        S_RDB  = 3'd2,
        S_CALC = 3'd3,
        S_WR   = 3'd4
    } ks_state_t;

endpackage
`default_nettype wire

// File: rtl/ks_delay_ram.sv
`default_nettype none
//==============================================================================
// Module : ks_delay_ram
// Desc   : Simple dual-port delay-line RAM, one write port, registered read.
// Rev    : 1.0 - initial release
//==============================================================================
module ks_delay_ram
    import ks_pkg::*;
#(
    parameter int DATA_W = c_DATA_W_DEF,
    parameter int ADDR_W = c_ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        o_rdata <= r_mem[i_raddr];
    end

endmodule
`default_nettype wire

// File: rtl/ks_string_voice.sv
`default_nettype none
//==============================================================================
// Module : ks_string_voice
// Desc   : Karplus-Strong plucked-string voice: burst load, then recirculate
//          through a two-tap averaging filter, one sample per tick.
// Rev    : 1.0 - initial release
//==============================================================================
module ks_string_voice
    import ks_pkg::*;
#(
    parameter int DATA_W      = c_DATA_W_DEF,
    parameter int ADDR_W      = c_ADDR_W_DEF,
    parameter int DECAY_SHIFT = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       div_freq,
    input  logic [9:0]        sel_nota,
    input  logic [DATA_W-1:0] noise,
    input  logic              noise_en,
    input  logic              noise_pulse,
    output logic [DATA_W-1:0] audio_out,
    output logic              audio_valid
);

    localparam logic [ADDR_W-1:0] c_LEN_MIN = ADDR_W'(c_MIN_LEN);

    logic [31:0]        r_tick_cnt;
    logic [31:0]        w_div_eff;
    logic               w_tick;
    logic               r_noise_en_d;
    logic               w_en_rise;
    logic               w_en_fall;
    logic [ADDR_W-1:0]  w_sel;
    logic [ADDR_W-1:0]  w_len_cur;
    logic [ADDR_W-1:0]  r_len;
    logic [ADDR_W-1:0]  r_ptr;
    logic [ADDR_W-1:0]  w_ptr_inc;
    logic [ADDR_W-1:0]  w_load_addr;
    logic [ADDR_W-1:0]  w_raddr;
    logic [ADDR_W-1:0]  w_waddr;
    logic               r_loaded;
    ks_state_t          r_state;
    ks_state_t          w_state_nxt;
    logic [DATA_W-1:0]  w_rdata;
    logic [DATA_W-1:0]  r_a;
    logic [DATA_W-1:0]  r_b;
    logic signed [DATA_W:0] w_sum;
    logic [DATA_W-1:0]  w_avg;
    logic [DATA_W-1:0]  w_y;
    logic [DATA_W-1:0]  r_audio_out;
    logic [DATA_W-1:0]  w_wdata;
    logic               r_valid;
    logic               w_we;

    function automatic logic [ADDR_W-1:0] f_wrap_inc(input logic [ADDR_W-1:0] p,
                                                     input logic [ADDR_W-1:0] len);
        logic [ADDR_W-1:0] n;
        n = p + ADDR_W'(1);
        return (n == len) ? '0 : n;
    endfunction

    // Comparing with >= keeps the period sane if div_freq shrinks mid-count
    assign w_div_eff = (div_freq < c_MIN_DIV) ? c_MIN_DIV : div_freq;
    assign w_tick    = (r_tick_cnt >= (w_div_eff - 32'd1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + 32'd1;
        end
    end

    assign w_en_rise   = noise_en & ~r_noise_en_d;
    assign w_en_fall   = ~noise_en & r_noise_en_d;
    assign w_sel       = ADDR_W'(sel_nota);
    assign w_len_cur   = (w_sel < c_LEN_MIN) ? c_LEN_MIN : w_sel;
    assign w_load_addr = w_en_rise ? '0 : r_ptr;
    assign w_ptr_inc   = f_wrap_inc(r_ptr, r_len);

    always_comb begin
        w_state_nxt = r_state;
        if (noise_en) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (w_tick && r_loaded) w_state_nxt = S_RDA;
                S_RDA:   w_state_nxt = S_RDB;
                S_RDB:   w_state_nxt = S_CALC;
                S_CALC:  w_state_nxt = S_WR;
                S_WR:    w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    assign w_sum = $signed({r_a[DATA_W-1], r_a}) + $signed({r_b[DATA_W-1], r_b});
    assign w_avg = DATA_W'(w_sum >>> 1);

    generate
        if (DECAY_SHIFT == 0) begin : g_no_decay
            assign w_y = w_avg;
        end else begin : g_decay
            assign w_y = w_avg - DATA_W'($signed(w_avg) >>> DECAY_SHIFT);
        end
    endgenerate

    // loaded is held low throughout LOAD so a tick on the falling-edge cycle is ignored
    always_ff @(posedge clk) begin
        if (reset) begin
            r_noise_en_d <= 1'b0;
            r_len        <= c_LEN_MIN;
            r_ptr        <= '0;
            r_loaded     <= 1'b0;
            r_a          <= '0;
            r_b          <= '0;
            r_audio_out  <= '0;
            r_valid      <= 1'b0;
        end else begin
            r_noise_en_d <= noise_en;
            r_valid      <= 1'b0;
            if (noise_en) begin
                r_loaded <= 1'b0;
                if (noise_pulse) begin
                    r_ptr <= f_wrap_inc(w_load_addr, w_len_cur);
                end else if (w_en_rise) begin
                    r_ptr <= '0;
                end
            end else if (w_en_fall) begin
                r_len    <= w_len_cur;
                r_ptr    <= '0;
                r_loaded <= 1'b1;
            end else begin
                if (r_state == S_RDA) r_a <= w_rdata;
                if (r_state == S_RDB) r_b <= w_rdata;
                if (r_state == S_CALC) begin
                    r_audio_out <= w_y;
                    r_valid     <= 1'b1;
                end
                if (r_state == S_WR) r_ptr <= w_ptr_inc;
            end
        end
    end

    assign w_raddr = (r_state == S_RDA) ? w_ptr_inc : r_ptr;
    assign w_we    = noise_en ? noise_pulse : (r_state == S_WR);
    assign w_waddr = noise_en ? w_load_addr : r_ptr;
    assign w_wdata = noise_en ? noise : r_audio_out;

    ks_delay_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

    assign audio_out   = r_audio_out;
    assign audio_valid = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_ks_string_voice.sv
`default_nettype none
//==============================================================================
// Module : tb_ks_string_voice
// Desc   : Self-checking bench for ks_string_voice with a behavioural string model.
// Rev    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
module tb_ks_string_voice;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] div_freq = 32'd10;
    logic [9:0]  sel_nota = '0;
    logic [15:0] noise = '0;
    logic        noise_en = 1'b0;
    logic        noise_pulse = 1'b0;
    logic [15:0] audio_out;
    logic        audio_valid;
    logic [15:0] audio_out_d;
    logic        audio_valid_d;

    int checks = 0;
    int errors = 0;
    int n_cnt  = 0;

    int mdl_mem [0:1023];
    int mdl_len = 2;
    int mdl_ptr = 0;

    ks_string_voice #(.DATA_W(16), .ADDR_W(10), .DECAY_SHIFT(0)) dut (
        .clk(clk), .reset(reset), .div_freq(div_freq), .sel_nota(sel_nota),
        .noise(noise), .noise_en(noise_en), .noise_pulse(noise_pulse),
        .audio_out(audio_out), .audio_valid(audio_valid)
    );

    ks_string_voice #(.DATA_W(16), .ADDR_W(10), .DECAY_SHIFT(4)) dut_decay (
        .clk(clk), .reset(reset), .div_freq(div_freq), .sel_nota(sel_nota),
        .noise(noise), .noise_en(noise_en), .noise_pulse(noise_pulse),
        .audio_out(audio_out_d), .audio_valid(audio_valid_d)
    );

    always #5 clk = ~clk;

    // Cycle index since reset release; cycle 0 has the tick counter at 0
    always @(posedge clk) begin
        if (reset) n_cnt <= 0;
        else       n_cnt <= n_cnt + 1;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic int floor_div(input int x, input int d);
        return (x >= 0) ? (x / d) : -((d - 1 - x) / d);
    endfunction

    function automatic int rand_s16();
        logic signed [15:0] s;
        s = 16'($urandom);
        return int'(s);
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic mdl_step(output int y);
        int a;
        int b;
        a = mdl_mem[mdl_ptr];
        b = mdl_mem[(mdl_ptr + 1) % mdl_len];
        y = floor_div(a + b, 2);
        mdl_mem[mdl_ptr] = y;
        mdl_ptr = (mdl_ptr + 1) % mdl_len;
    endtask

    task automatic do_reset(input int dv);
        div_freq    = 32'(dv);
        reset       = 1'b1;
        noise_en    = 1'b0;
        noise_pulse = 1'b0;
        step(2);
        reset = 1'b0;
    endtask

    // mode 0: rise then pulses; mode 1: first pulse on the rise cycle; mode 2: already in LOAD
    task automatic load_burst(input int sel, input int vals[$], input int mode);
        int lc;
        lc = (sel < 2) ? 2 : sel;
        sel_nota = 10'(sel);
        if (mode != 2) step(1);
        if (mode == 0) begin
            noise_en    = 1'b1;
            noise_pulse = 1'b0;
            step(1 + $urandom_range(0, 1));
        end else if (mode == 1) begin
            noise_en = 1'b1;
        end
        foreach (vals[i]) begin
            noise       = 16'(vals[i]);
            noise_pulse = 1'b1;
            step(1);
            noise_pulse = 1'b0;
            mdl_mem[i % lc] = vals[i];
            if ($urandom_range(0, 2) == 0) step(1);
        end
        noise_en = 1'b0;
        step(1);
        mdl_len = lc;
        mdl_ptr = 0;
    endtask

    task automatic expect_outputs(input int nout, input int dv, input bit junk, input string tag);
        int  d;
        int  last_n;
        int  y;
        bit  found;
        d = (dv < 5) ? 5 : dv;
        last_n = -1;
        for (int k = 0; k < nout; k++) begin
            mdl_step(y);
            found = 1'b0;
            for (int w = 0; w < 2 * d + 10; w++) begin
                if (junk) begin
                    noise_pulse = 1'($urandom_range(0, 1));
                    noise       = 16'($urandom);
                    sel_nota    = 10'($urandom_range(0, 20));
                end
                step(1);
                if (audio_valid === 1'b1) begin
                    found = 1'b1;
                    break;
                end
            end
            noise_pulse = 1'b0;
            checks++;
            if (!found) begin
                errors++;
                $display("FAIL %s timeout: no audio_valid for output %0d, required value %0d", tag, k, y);
                return;
            end
            if (audio_out !== 16'(y)) begin
                errors++;
                $display("FAIL %s sample %0d: audio_out=%0d required %0d", tag, k, $signed(audio_out), y);
            end
            checks++;
            if ((n_cnt + d - 3) % d != 0) begin
                errors++;
                $display("FAIL %s latency sample %0d: valid at cycle %0d, required tick+4 with D=%0d", tag, k, n_cnt, d);
            end
            if (last_n >= 0) begin
                checks++;
                if (n_cnt - last_n != d) begin
                    errors++;
                    $display("FAIL %s spacing sample %0d: %0d cycles required %0d", tag, k, n_cnt - last_n, d);
                end
            end
            last_n = n_cnt;
        end
    endtask

    task automatic test_reset();
        int vcnt;
        int nz;
        div_freq    = 32'd10;
        reset       = 1'b1;
        noise_en    = 1'b0;
        noise_pulse = 1'b0;
        step(3);
        checks++;
        if (audio_out !== 16'd0) begin
            errors++;
            $display("FAIL reset_out: audio_out=%0d required 0", audio_out);
        end
        checks++;
        if (audio_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid: audio_valid=%b required 0", audio_valid);
        end
        reset = 1'b0;
        vcnt = 0;
        nz = 0;
        for (int i = 0; i < 200; i++) begin
            noise_pulse = 1'($urandom_range(0, 1));
            noise       = 16'($urandom);
            step(1);
            if (audio_valid !== 1'b0) vcnt++;
            if (audio_out !== 16'd0) nz++;
        end
        noise_pulse = 1'b0;
        checks++;
        if (vcnt != 0) begin
            errors++;
            $display("FAIL unloaded_valid: %0d strobes required 0", vcnt);
        end
        checks++;
        if (nz != 0) begin
            errors++;
            $display("FAIL unloaded_out: %0d nonzero cycles required 0", nz);
        end
    endtask

    task automatic test_len4();
        int q[$];
        do_reset(10);
        q = {};
        q.push_back(100); q.push_back(200); q.push_back(-300); q.push_back(400);
        load_burst(4, q, 0);
        expect_outputs(5, 10, 1'b0, "len4");
    endtask

    task automatic test_len3_wrap();
        int q[$];
        do_reset(7);
        q = {};
        for (int i = 1; i <= 5; i++) q.push_back(i);
        load_burst(3, q, 1);
        expect_outputs(6, 7, 1'b0, "len3_wrap");
    endtask

    task automatic test_min_len();
        int q[$];
        do_reset(1);
        q = {};
        q.push_back(10); q.push_back(20);
        load_burst(0, q, 0);
        expect_outputs(3, 1, 1'b0, "min_len");
    endtask

    task automatic test_extremes();
        int q[$];
        int pa[3];
        int pb[3];
        pa[0] = -32768; pb[0] = -32768;
        pa[1] = 32767;  pb[1] = 32767;
        pa[2] = -1;     pb[2] = 0;
        do_reset(5);
        for (int i = 0; i < 3; i++) begin
            q = {};
            q.push_back(pa[i]); q.push_back(pb[i]);
            load_burst(2, q, 0);
            expect_outputs(2, 5, 1'b0, "extremes");
        end
    endtask

    task automatic test_decay();
        int q[$];
        int av[2];
        int avg;
        int yd;
        av[0] = 160;
        av[1] = -161;
        do_reset(6);
        for (int i = 0; i < 2; i++) begin
            q = {};
            q.push_back(av[i]); q.push_back(av[i]);
            load_burst(2, q, 0);
            expect_outputs(1, 6, 1'b0, "decay_base");
            avg = floor_div(av[i] + av[i], 2);
            yd  = avg - floor_div(avg, 16);
            checks++;
            if (audio_valid_d !== 1'b1 || audio_out_d !== 16'(yd)) begin
                errors++;
                $display("FAIL decay: valid=%b audio_out=%0d required valid=1 value %0d",
                         audio_valid_d, $signed(audio_out_d), yd);
            end
        end
    endtask

    task automatic test_abort();
        int q[$];
        int seen;
        do_reset(8);
        q = {};
        for (int i = 0; i < 4; i++) q.push_back(rand_s16());
        load_burst(4, q, 0);
        expect_outputs(2, 8, 1'b0, "abort_pre");
        for (int w = 0; w < 20; w++) begin
            step(1);
            if ((n_cnt + 8 - 2) % 8 == 0) break;
        end
        noise_en = 1'b1;
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            step(1);
            if (audio_valid !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL abort_valid: %0d strobes after abort required 0", seen);
        end
        q = {};
        for (int i = 0; i < 4; i++) q.push_back(rand_s16());
        load_burst(4, q, 2);
        expect_outputs(4, 8, 1'b0, "abort_post");
    endtask

    task automatic test_reset_mid();
        int q[$];
        int seen;
        do_reset(6);
        q = {};
        for (int i = 0; i < 5; i++) q.push_back(rand_s16());
        load_burst(5, q, 0);
        expect_outputs(2, 6, 1'b0, "mid_pre");
        step(2);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        checks++;
        if (audio_out !== 16'd0 || audio_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: audio_out=%0d valid=%b required 0/0", $signed(audio_out), audio_valid);
        end
        seen = 0;
        for (int i = 0; i < 60; i++) begin
            step(1);
            if (audio_valid !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL mid_reset_idle: %0d strobes without reload required 0", seen);
        end
        q = {};
        for (int i = 0; i < 5; i++) q.push_back(rand_s16());
        load_burst(5, q, 0);
        expect_outputs(3, 6, 1'b0, "mid_reload");
    endtask

    task automatic test_random();
        int q[$];
        int dv;
        int sel;
        int lc;
        int n;
        for (int r = 0; r < 6; r++) begin
            dv  = $urandom_range(0, 12);
            sel = $urandom_range(0, 12);
            lc  = (sel < 2) ? 2 : sel;
            n   = lc + $urandom_range(0, lc);
            do_reset(dv);
            q = {};
            for (int i = 0; i < n; i++) q.push_back(rand_s16());
            load_burst(sel, q, $urandom_range(0, 1));
            expect_outputs(2 * lc + 3, dv, 1'b1, "random");
        end
    endtask

    initial begin
        test_reset();
        test_len4();
        test_len3_wrap();
        test_min_len();
        test_extremes();
        test_decay();
        test_abort();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
